layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer_if.sv | 36 +++
 rtl/layer_sequencer.sv | 100 ++++++++++
 tb/tb_layer_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// Handshake and data bundle between the layer sequencer, its vector source,
// the neuron layer it drives and the result consumer.
interface layer_sequencer_if #(
  parameter int numInputs  = 16,
  parameter int numNeurons = 10,
  parameter int dataWidth  = 16
);
  localparam int classWidth = $clog2(numNeurons);

  logic                            inValid;
  logic                            inReady;
  logic [dataWidth*numInputs-1:0]  inData;
  logic [dataWidth*numInputs-1:0]  layerIn;
  logic                            layerValid;
  logic                            layerClear;
  logic [dataWidth*numNeurons-1:0] layerOut;
  logic                            layerOutValid;
  logic                            outValid;
  logic                            outReady;
  logic [dataWidth*numNeurons-1:0] outData;
  logic [classWidth-1:0]           outClass;
  logic                            outTimeout;
  logic                            busy;

  modport master (
    input  inValid, inData, layerOut, layerOutValid, outReady,
    output inReady, layerIn, layerValid, layerClear,
           outValid, outData, outClass, outTimeout, busy
  );

  modport slave (
    output inValid, inData, layerOut, layerOutValid, outReady,
    input  inReady, layerIn, layerValid, layerClear,
           outValid, outData, outClass, outTimeout, busy
  );
endinterface

// File: rtl/layer_sequencer.sv
// Sequences one inference through a neuron layer: latch vector, clear, run
// until results or timeout, then a serial signed argmax over the results.
module layer_sequencer #(
  parameter int numInputs     = 16,
  parameter int numNeurons    = 10,
  parameter int dataWidth     = 16,
  parameter int timeoutCycles = 64
) (
  input logic               clk,
  input logic               reset,
  layer_sequencer_if.master bus
);
  localparam int classWidth = $clog2(numNeurons);
  localparam int cntWidth   = $clog2(timeoutCycles + 1);
  localparam logic [classWidth-1:0] lastIdx      = classWidth'(numNeurons - 1);
  localparam logic [cntWidth-1:0]   timeoutCount = cntWidth'(timeoutCycles);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, ARGMAX, DONE} state_t;

  state_t                       state;
  state_t                       stateNext;
  logic [cntWidth-1:0]          runCount;
  logic [classWidth-1:0]        scanIdx;
  logic signed [dataWidth-1:0]  bestVal;
  logic signed [dataWidth-1:0]  capturedWords [numNeurons];
  logic signed [dataWidth-1:0]  scanWord;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (bus.inValid) stateNext = CLEAR;
      CLEAR:   stateNext = RUN;
      // Layer results win over a timeout landing in the same cycle.
      RUN:     if (bus.layerOutValid)           stateNext = ARGMAX;
               else if (runCount == timeoutCount) stateNext = DONE;
      ARGMAX:  if (scanIdx == lastIdx) stateNext = DONE;
      DONE:    if (bus.outReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign bus.inReady    = (state == IDLE);
  assign bus.layerClear = (state == CLEAR);
  assign bus.layerValid = (state == RUN);
  assign bus.outValid   = (state == DONE);
  assign bus.busy       = (state != IDLE);

  // Argmax scans the captured copy, so the layer may change its outputs freely.
  always_comb begin
    for (int unsigned k = 0; k < numNeurons; k++) begin
      capturedWords[k] = bus.outData[k*dataWidth +: dataWidth];
    end
    scanWord = capturedWords[scanIdx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.layerIn    <= '0;
      bus.outData    <= '0;
      bus.outClass   <= '0;
      bus.outTimeout <= 1'b0;
      runCount       <= '0;
      scanIdx        <= '0;
      bestVal        <= '0;
    end else begin
      if (state == IDLE && bus.inValid) bus.layerIn <= bus.inData;

      if (state == CLEAR)    runCount <= cntWidth'(1);
      else if (state == RUN) runCount <= runCount + cntWidth'(1);

      if (state == RUN) begin
        if (bus.layerOutValid) begin
          bus.outData    <= bus.layerOut;
          bus.outClass   <= '0;
          bus.outTimeout <= 1'b0;
          bestVal        <= $signed(bus.layerOut[dataWidth-1:0]);
          scanIdx        <= classWidth'(1);
        end else if (runCount == timeoutCount) begin
          bus.outData    <= '0;
          bus.outClass   <= '0;
          bus.outTimeout <= 1'b1;
        end
      end

      // Strict greater-than keeps the lowest index on ties.
      if (state == ARGMAX) begin
        if (scanWord > bestVal) begin
          bestVal      <= scanWord;
          bus.outClass <= scanIdx;
        end
        scanIdx <= scanIdx + classWidth'(1);
      end
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: the bench plays vector source, layer and
// consumer; a scoreboard queue holds expected results for the output monitor.
module tb_layer_sequencer;
  localparam int NI = 16;
  localparam int NN = 10;
  localparam int DW = 16;
  localparam int TO = 64;

  typedef struct {
    logic [NN*DW-1:0] data;
    logic [3:0]       cls;
    logic             tmo;
    int               due;
  } sbEntry_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   misses = 0;
  bit   prevOv = 1'b0;
  sbEntry_t sbQ[$];

  layer_sequencer_if #(.numInputs(NI), .numNeurons(NN), .dataWidth(DW)) bus ();

  layer_sequencer #(
    .numInputs(NI), .numNeurons(NN), .dataWidth(DW), .timeoutCycles(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [NN*DW-1:0] act,
                       input logic [NN*DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NN*DW-1:0] mk(input logic [DW-1:0] base,
      input int i1, input logic [DW-1:0] v1, input int i2, input logic [DW-1:0] v2);
    logic [NN*DW-1:0] w;
    for (int k = 0; k < NN; k++) w[k*DW +: DW] = base;
    if (i1 >= 0) w[i1*DW +: DW] = v1;
    if (i2 >= 0) w[i2*DW +: DW] = v2;
    return w;
  endfunction

  // Output monitor: every rising outValid must match the oldest expectation.
  always @(negedge clk) begin
    sbEntry_t e;
    if (bus.outValid && !prevOv) begin
      if (sbQ.size() == 0) begin
        check("unexpected_out", {159'b0, bus.outValid}, '0);
      end else begin
        e = sbQ.pop_front();
        check("mon_data",    bus.outData,    e.data);
        check("mon_class",   bus.outClass,   e.cls);
        check("mon_timeout", bus.outTimeout, e.tmo);
        check("mon_latency", cyc,            e.due);
      end
    end
    prevOv = bus.outValid;
  end

  // One inference: k = RUN cycle (1-based) in which the layer reports, 0 = never.
  task automatic runVector(input string name, input logic [NI*DW-1:0] vec,
      input logic [NN*DW-1:0] words, input int k, input logic [3:0] expCls,
      input logic expTmo, input int hold);
    int t, due, lvCount, clrCount, waitN;
    bit seen;
    logic [NN*DW-1:0] expData;
    sbEntry_t e;
    expData  = expTmo ? '0 : words;
    seen     = 1'b0;
    lvCount  = 0;
    clrCount = 0;
    waitN    = 0;
    bus.outReady = (hold == 0);
    @(posedge clk); #1;
    bus.inValid = 1'b1;
    bus.inData  = vec;
    @(negedge clk);
    while (!bus.inReady && waitN < 50) begin
      @(negedge clk);
      waitN++;
    end
    check({name, "_accept"}, {159'b0, bus.inReady}, 1);
    if (!bus.inReady) begin
      bus.inValid = 1'b0;
      return;
    end
    t   = cyc;
    due = (k > 0) ? t + 1 + k + NN : t + 2 + TO;
    e.data = expData; e.cls = expCls; e.tmo = expTmo; e.due = due;
    sbQ.push_back(e);
    @(posedge clk); #1;
    bus.inValid = 1'b0;
    bus.inData  = ~vec;
    for (int c = t + 1; c < t + 200; c++) begin
      if (k > 0 && c == t + 1 + k) begin
        bus.layerOutValid = 1'b1;
        bus.layerOut      = words;
      end else begin
        bus.layerOutValid = 1'b0;
        bus.layerOut      = ~words;
      end
      @(negedge clk);
      if (bus.layerValid) lvCount++;
      if (bus.layerClear) clrCount++;
      if (c == t + 1) check({name, "_layerIn"}, bus.layerIn, vec);
      if (bus.outValid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.layerOutValid = 1'b0;
    check({name, "_done_seen"}, {159'b0, seen}, 1);
    check({name, "_run_cycles"}, lvCount, (k > 0) ? k : TO);
    check({name, "_clear_pulses"}, clrCount, 1);
    for (int h = 0; h < hold; h++) begin
      check({name, "_hold_valid"}, {159'b0, bus.outValid}, 1);
      check({name, "_hold_data"},  bus.outData, expData);
      check({name, "_hold_class"}, bus.outClass, expCls);
      check({name, "_hold_ready"}, {159'b0, bus.inReady}, 0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    bus.outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({name, "_back_idle"}, {158'b0, bus.inReady, bus.outValid}, 2'b10);
  endtask

  logic [NN*DW-1:0] basicWords;
  int tr;

  initial begin
    reset             = 1'b1;
    bus.inValid       = 1'b0;
    bus.inData        = '0;
    bus.layerOut      = '0;
    bus.layerOutValid = 1'b0;
    bus.outReady      = 1'b1;
    basicWords = mk(16'h0100, 3, 16'h0400, -1, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_layerIn",  bus.layerIn, '0);
    check("rst_outData",  bus.outData, '0);
    check("rst_flags", {152'b0, bus.layerValid, bus.layerClear, bus.outValid,
          bus.outClass, bus.outTimeout},
          {152'b0, 8'b0});
    check("rst_handshake", {158'b0, bus.busy, bus.inReady}, 2'b01);

    // Stray layer result and data change while idle must be ignored.
    @(posedge clk); #1;
    bus.inData        = {NI{16'h1234}};
    bus.layerOutValid = 1'b1;
    bus.layerOut      = basicWords;
    @(posedge clk); #1;
    bus.layerOutValid = 1'b0;
    @(negedge clk);
    check("idle_ignore_layerIn", bus.layerIn, '0);
    check("idle_ignore_out", {158'b0, bus.outValid, bus.busy}, 2'b00);
    check("idle_ignore_data", bus.outData, '0);

    runVector("basic",   {NI{16'h00A1}}, basicWords, 19, 4'd3, 1'b0, 0);
    runVector("tie",     {NI{16'h0B02}}, mk(16'hFF00, 2, 16'h0200, 7, 16'h0200), 5, 4'd2, 1'b0, 0);
    runVector("neg",     {NI{16'hC003}}, mk(16'hFC00, 9, 16'hFF00, -1, '0), 1, 4'd9, 1'b0, 0);
    runVector("word0",   {NI{16'h5A04}}, mk(16'h8000, 0, 16'h7FFF, 9, 16'h7FFE), 3, 4'd0, 1'b0, 0);
    runVector("timeout", {NI{16'h7705}}, '0, 0, 4'd0, 1'b1, 0);
    runVector("prio",    {NI{16'h3306}}, basicWords, TO, 4'd3, 1'b0, 0);
    runVector("bp",      {NI{16'h0E07}}, mk(16'h0010, 6, 16'h0300, -1, '0), 10, 4'd6, 1'b0, 5);

    // Reset asserted during the 10th RUN cycle discards the run.
    @(posedge clk); #1;
    bus.inValid = 1'b1;
    bus.inData  = {NI{16'hDEAD}};
    @(negedge clk);
    tr = cyc;
    check("rstrun_accept", {159'b0, bus.inReady}, 1);
    @(posedge clk); #1;
    bus.inValid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rstrun_in_run", {159'b0, bus.layerValid}, 1);
    check("rstrun_cycle", cyc, tr + 11);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstrun_flags", {156'b0, bus.layerValid, bus.outValid, bus.busy, bus.inReady}, 4'b0001);
    check("rstrun_outData", bus.outData, '0);
    check("rstrun_layerIn", bus.layerIn, '0);
    runVector("after_rst", {NI{16'h0F08}}, basicWords, 19, 4'd3, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sbQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
